// File: rtl/lin_recur_seq_gen.sv
// lin_recur_seq_gen: streaming source for a linear recurrence a[n] = sum tap[k]*a[n-1-k].
// Starts from the impulse a[-1]=1, a[-2..-Order]=0 and emits len terms over valid/ready.
// Built-in modes: Fibonacci, Tribonacci, Padovan, or a runtime custom tap mask.
// Arithmetic wraps modulo 2^DataBus, and a sticky flag reports any wrap since the last start.
module lin_recur_seq_gen #(
  parameter int DataBus = 32,
  parameter int Order   = 4,
  parameter int CntW    = 16
) (
  input  logic               clk_w,
  input  logic               reset_n_w,
  input  logic               start_w,
  input  logic               abort_w,
  input  logic [1:0]         mode_w,
  input  logic [Order-1:0]   tap_mask_w,
  input  logic [CntW-1:0]    len_w,
  input  logic               ready_i_w,
  output logic [DataBus-1:0] seq_o_w,
  output logic               valid_o_w,
  output logic [CntW-1:0]    idx_o_w,
  output logic               busy_o_w,
  output logic               done_o_w,
  output logic               ovf_o_w
);

  // Wide enough to hold the sum of Order terms without losing the carry bits.
  localparam int SumW = DataBus + $clog2(Order);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                    state_r;
  logic [Order-1:0][DataBus-1:0] hist_r;      // hist_r[k] = a[idx-1-k]
  logic [Order-1:0]              mask_r;
  logic [CntW-1:0]               len_r;
  logic [DataBus-1:0]            seq_r;
  logic [CntW-1:0]               idx_r;
  logic                          valid_r;
  logic                          done_r;
  logic                          ovf_r;

  logic [Order-1:0][DataBus-1:0] hist_shift_s;
  logic [Order-1:0][DataBus-1:0] hist_init_s;
  logic [Order-1:0]              start_mask_s;
  logic [SumW-1:0]               sum_shift_s;
  logic [SumW-1:0]               sum_init_s;
  logic                          xfer_s;
  logic                          last_s;
  logic                          wrap_s;

  // Tap mask selected by the mode field; bit k weights a[n-1-k].
  function automatic logic [Order-1:0] mode_mask(input logic [1:0] mode,
                                                 input logic [Order-1:0] custom);
    logic [Order-1:0] m;
    m = '0;
    case (mode)
      2'b00:   m[1:0] = 2'b11;
      2'b01:   m[2:0] = 3'b111;
      2'b10:   m[2:1] = 2'b11;
      2'b11:   m      = custom;
      default: m      = '0;
    endcase
    return m;
  endfunction

  // Sum of the history entries selected by the mask, carried out at full width.
  function automatic logic [SumW-1:0] masked_sum(input logic [Order-1:0][DataBus-1:0] h,
                                                 input logic [Order-1:0] m);
    logic [SumW-1:0] acc;
    acc = '0;
    for (int k = 0; k < Order; k++) begin
      if (m[k]) begin
        acc = acc + SumW'(h[k]);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  // Next-term datapath: the shifted history and its sum, plus the impulse start history.
  always_comb begin
    hist_shift_s    = '0;
    hist_shift_s[0] = seq_r;
    for (int k = 1; k < Order; k++) begin
      hist_shift_s[k] = hist_r[k-1];
    end
    hist_init_s    = '0;
    hist_init_s[0] = DataBus'(1);
    start_mask_s   = mode_mask(mode_w, tap_mask_w);
    sum_init_s     = masked_sum(hist_init_s, start_mask_s);
    sum_shift_s    = masked_sum(hist_shift_s, mask_r);
    wrap_s         = (sum_shift_s[SumW-1:DataBus] != '0);
    xfer_s         = valid_r && ready_i_w;
    last_s         = (idx_r == (len_r - CntW'(1)));
  end

  // Control FSM and the output/history registers.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      state_r <= IDLE;
      hist_r  <= '0;
      mask_r  <= '0;
      len_r   <= '0;
      seq_r   <= '0;
      idx_r   <= '0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start_w) begin
            mask_r <= start_mask_s;
            len_r  <= len_w;
            ovf_r  <= 1'b0;
            hist_r <= hist_init_s;
            idx_r  <= '0;
            if (len_w != '0) begin
              state_r <= RUN;
              seq_r   <= sum_init_s[DataBus-1:0];
              valid_r <= 1'b1;
            end else begin
              state_r <= DONE;
              valid_r <= 1'b0;
              done_r  <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          // Abort wins over a transfer happening in the same cycle.
          if (abort_w) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            idx_r   <= '0;
          end else if (xfer_s) begin
            if (last_s) begin
              valid_r <= 1'b0;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              hist_r <= hist_shift_s;
              seq_r  <= sum_shift_s[DataBus-1:0];
              idx_r  <= idx_r + CntW'(1);
              ovf_r  <= ovf_r | wrap_s;
            end
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign seq_o_w   = seq_r;
  assign valid_o_w = valid_r;
  assign idx_o_w   = idx_r;
  assign busy_o_w  = (state_r != IDLE);
  assign done_o_w  = done_r;
  assign ovf_o_w   = ovf_r;

endmodule

// File: tb/tb_lin_recur_seq_gen.sv
// Bench for lin_recur_seq_gen: a 32-bit and an 8-bit instance share all stimulus, and both are
// checked against a queue-free arithmetic model of the recurrence.
module tb_lin_recur_seq_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ready = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [3:0]  mask = 4'd0;
  logic [15:0] len = 16'd0;

  logic [31:0] seq32;
  logic [7:0]  seq8;
  logic [15:0] idx32, idx8;
  logic        valid32, valid8, busy32, busy8, done32, done8, ovf32, ovf8;

  int total = 0;
  int bad = 0;

  longint unsigned e32[0:63];
  longint unsigned e8[0:63];
  bit              o32[0:63];
  bit              o8[0:63];

  lin_recur_seq_gen dut32 (
    .clk_w(clk), .reset_n_w(reset_n), .start_w(start), .abort_w(abort), .mode_w(mode),
    .tap_mask_w(mask), .len_w(len), .ready_i_w(ready), .seq_o_w(seq32), .valid_o_w(valid32),
    .idx_o_w(idx32), .busy_o_w(busy32), .done_o_w(done32), .ovf_o_w(ovf32)
  );

  lin_recur_seq_gen #(.DataBus(8)) dut8 (
    .clk_w(clk), .reset_n_w(reset_n), .start_w(start), .abort_w(abort), .mode_w(mode),
    .tap_mask_w(mask), .len_w(len), .ready_i_w(ready), .seq_o_w(seq8), .valid_o_w(valid8),
    .idx_o_w(idx8), .busy_o_w(busy8), .done_o_w(done8), .ovf_o_w(ovf8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] taps_of(input logic [1:0] md, input logic [3:0] cm);
    case (md)
      2'b00:   return 4'b0011;
      2'b01:   return 4'b0111;
      2'b10:   return 4'b0110;
      default: return cm;
    endcase
  endfunction

  // Reference: a[i] = sum of tapped earlier terms, wrapped to w bits; ovf sticky from first wrap.
  task automatic model_w(input int w, input logic [3:0] tp, input int n,
                         output longint unsigned vals[0:63], output bit ovs[0:63]);
    longint unsigned a[0:67];
    longint unsigned lim;
    longint unsigned s;
    bit ov;
    lim = 64'd1 << w;
    for (int j = 0; j < 68; j++) a[j] = 64'd0;
    a[3] = 64'd1;   // a[-1]; a[i] is stored at a[i+4]
    ov = 1'b0;
    for (int j = 0; j < 64; j++) begin
      vals[j] = 64'd0;
      ovs[j]  = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      s = 64'd0;
      for (int k = 0; k < 4; k++) if (tp[k]) s = s + a[i+3-k];
      if (s >= lim) ov = 1'b1;
      s = s % lim;
      a[i+4]  = s;
      vals[i] = s;
      ovs[i]  = ov;
    end
  endtask

  // One complete run: kill_at >= 0 interrupts at that index (kind 0 abort, kind 1 reset).
  task automatic run(input string nm, input logic [1:0] md, input logic [3:0] cm, input int n,
                     input int rmode, input int kill_at, input int kill_kind);
    int  k;
    int  cyc;
    bit  r;
    logic [3:0] tp;
    tp = taps_of(md, cm);
    model_w(32, tp, n, e32, o32);
    model_w(8, tp, n, e8, o8);
    // abort while idle must do nothing
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk({nm, "_idle_abort_busy"}, 64'(busy32), 64'd0);
    mode = md; mask = cm; len = 16'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) begin
      chk({nm, "_zero_valid32"}, 64'(valid32), 64'd0);
      chk({nm, "_zero_valid8"}, 64'(valid8), 64'd0);
      chk({nm, "_zero_busy"}, 64'(busy32), 64'd1);
      chk({nm, "_zero_done"}, 64'(done32), 64'd1);
      @(posedge clk); #1;
      chk({nm, "_zero_busy_end"}, 64'(busy32), 64'd0);
      chk({nm, "_zero_done_end"}, 64'(done32), 64'd0);
      chk({nm, "_zero_valid_end"}, 64'(valid32), 64'd0);
      return;
    end
    k = 0; cyc = 0; r = 1'b1;
    while (k < n && cyc < 20 * n + 50) begin
      chk({nm, "_seq32"}, 64'(seq32), e32[k]);
      chk({nm, "_seq8"}, 64'(seq8), e8[k]);
      chk({nm, "_idx32"}, 64'(idx32), 64'(k));
      chk({nm, "_idx8"}, 64'(idx8), 64'(k));
      chk({nm, "_valid"}, 64'({valid32, valid8}), 64'd3);
      chk({nm, "_busy_done"}, 64'({busy32, done32}), 64'b10);
      chk({nm, "_ovf32"}, 64'(ovf32), 64'(o32[k]));
      chk({nm, "_ovf8"}, 64'(ovf8), 64'(o8[k]));
      if (k == kill_at) begin
        if (kill_kind == 0) begin
          abort = 1'b1; ready = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0; ready = 1'b0;
          chk({nm, "_abort_valid"}, 64'({valid32, valid8}), 64'd0);
          chk({nm, "_abort_idx"}, 64'(idx32), 64'd0);
          chk({nm, "_abort_busy"}, 64'(busy32), 64'd0);
          chk({nm, "_abort_done"}, 64'(done32), 64'd0);
          chk({nm, "_abort_ovf8"}, 64'(ovf8), 64'(o8[k]));
          @(posedge clk); #1;
          chk({nm, "_abort_no_done"}, 64'(done32), 64'd0);
        end else begin
          reset_n = 1'b0;
          #1;
          chk({nm, "_rst_seq"}, 64'({seq32, seq8}), 64'd0);
          chk({nm, "_rst_idx"}, 64'({idx32, idx8}), 64'd0);
          chk({nm, "_rst_flags"},
              64'({valid32, valid8, busy32, busy8, done32, done8, ovf32, ovf8}), 64'd0);
          @(posedge clk); #1;
          reset_n = 1'b1;
        end
        return;
      end
      case (rmode)
        0:       ready = 1'b1;
        1:       begin ready = r; r = ~r; end
        default: ready = 1'($urandom_range(0, 1));
      endcase
      // live config changes and start requests must be ignored while running
      mode = 2'($urandom); mask = 4'($urandom); len = 16'($urandom);
      start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      start = 1'b0;
      if (ready) k++;
      cyc++;
    end
    ready = 1'b0;
    chk({nm, "_count"}, 64'(k), 64'(n));
    chk({nm, "_end_valid"}, 64'({valid32, valid8}), 64'd0);
    chk({nm, "_end_done"}, 64'({done32, done8}), 64'd3);
    chk({nm, "_end_busy"}, 64'(busy32), 64'd1);
    chk({nm, "_end_ovf32"}, 64'(ovf32), 64'(o32[n-1]));
    chk({nm, "_end_ovf8"}, 64'(ovf8), 64'(o8[n-1]));
    start = 1'b1;   // ignored in DONE
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_idle_busy"}, 64'(busy32), 64'd0);
    chk({nm, "_idle_done"}, 64'(done32), 64'd0);
    chk({nm, "_idle_valid"}, 64'(valid32), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_seq", 64'({seq32, seq8}), 64'd0);
    chk("reset_flags", 64'({valid32, busy32, done32, ovf32, valid8, busy8, done8, ovf8}), 64'd0);
    chk("reset_idx", 64'({idx32, idx8}), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run("t1_fib", 2'b00, 4'b0000, 8, 0, -1, 0);
    run("t2_pad", 2'b10, 4'b0000, 9, 1, -1, 0);
    run("t3_trib", 2'b01, 4'b0000, 12, 0, -1, 0);
    run("t4_len0", 2'b00, 4'b0000, 0, 0, -1, 0);
    run("t5_custom", 2'b11, 4'b1001, 8, 0, -1, 0);
    run("t6a_abort", 2'b00, 4'b0000, 8, 0, 3, 0);
    run("t6a_refib", 2'b00, 4'b0000, 8, 0, -1, 0);
    run("t6b_reset", 2'b00, 4'b0000, 8, 2, 4, 1);
    run("t6b_refib", 2'b00, 4'b0000, 8, 0, -1, 0);
    run("mask0", 2'b11, 4'b0000, 6, 2, -1, 0);
    for (int i = 0; i < 12; i++) begin
      logic [1:0] md;
      logic [3:0] cm;
      int n;
      int kill;
      md = 2'($urandom);
      cm = 4'($urandom);
      n = $urandom_range(1, 40);
      kill = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      run("rand", md, cm, n, 2, kill, int'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
